// File: rtl/shift_scheduler.sv
// Round-robin arbiter sharing one sll/srl/sra shifter between two requesters, one registered result slot.
// Optional grant counters: define SHIFT_STATS_EN to add grant_cnt0/grant_cnt1.
module shift_scheduler #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic [1:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic [1:0]         req1_op,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_y,
  output logic               rsp_id
`ifdef SHIFT_STATS_EN
  ,
  output logic [CNT_W-1:0]   grant_cnt0,
  output logic [CNT_W-1:0]   grant_cnt1
`endif
);

  typedef enum logic {IDLE, FULL} state_t;

  state_t               state;
  logic                 last_grant;
  logic                 slot_free;
  logic                 grant0;
  logic                 grant1;
  logic                 accept;
  logic [WIDTH-1:0]     sel_a;
  logic [SHAMT_W-1:0]   sel_shamt;
  logic [1:0]           sel_op;
  logic [WIDTH-1:0]     shifted;

  function automatic logic [WIDTH-1:0] do_shift(input logic [WIDTH-1:0] a,
                                                input logic [SHAMT_W-1:0] s,
                                                input logic [1:0] op);
    logic [WIDTH-1:0] r;
    case (op)
      2'b00:   r = a << s;
      2'b01:   r = a >> s;
      2'b10:   r = $unsigned($signed(a) >>> s);
      default: r = a;
    endcase
    return r;
  endfunction

  // A full slot frees up in the same cycle the consumer drains it, keeping 1 op/cycle.
  assign slot_free = (state == IDLE) || rsp_ready;

  // On a tie the requester that did not win last time goes first.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  assign req0_ready = !reset && slot_free && grant0;
  assign req1_ready = !reset && slot_free && grant1;
  assign accept     = req0_ready || req1_ready;

  assign sel_a     = req1_ready ? req1_a     : req0_a;
  assign sel_shamt = req1_ready ? req1_shamt : req0_shamt;
  assign sel_op    = req1_ready ? req1_op    : req0_op;
  assign shifted   = do_shift(sel_a, sel_shamt, sel_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rsp_valid  <= 1'b0;
      rsp_y      <= '0;
      rsp_id     <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= FULL;
            rsp_valid  <= 1'b1;
            rsp_y      <= shifted;
            rsp_id     <= req1_ready;
            last_grant <= req1_ready;
          end
        end
        FULL: begin
          if (accept) begin
            rsp_y      <= shifted;
            rsp_id     <= req1_ready;
            last_grant <= req1_ready;
          end else if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SHIFT_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready && grant_cnt0 != {CNT_W{1'b1}}) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (req1_ready && grant_cnt1 != {CNT_W{1'b1}}) grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_scheduler.sv
// Bench for shift_scheduler: directed scenarios plus random traffic against a cycle-level reference model.
module tb_shift_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_a, req1_a;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [1:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_y;
`ifdef SHIFT_STATS_EN
  logic [15:0] grant_cnt0, grant_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state (m_*), next state (n_*), expected readies (e_*)
  logic        m_full, m_id, m_last, n_full, n_id, n_last, e_rdy0, e_rdy1;
  logic [31:0] m_y, n_y;
  int          m_c0, m_c1, n_c0, n_c1;

  shift_scheduler dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
    .req0_shamt(req0_shamt), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
    .req1_shamt(req1_shamt), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_id(rsp_id)
`ifdef SHIFT_STATS_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  // Bitwise definition of the shift rules.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input int s, input logic [1:0] op);
    logic [31:0] y;
    for (int i = 0; i < 32; i++) begin
      case (op)
        2'b00:   y[i] = (i >= s) ? a[i-s] : 1'b0;
        2'b01:   y[i] = (i + s <= 31) ? a[i+s] : 1'b0;
        2'b10:   y[i] = (i + s <= 31) ? a[i+s] : a[31];
        default: y[i] = a[i];
      endcase
    end
    return y;
  endfunction

  task automatic model_eval();
    logic free, want0, want1;
    free  = !m_full || rsp_ready;
    want0 = req0_valid && (!req1_valid || m_last);
    want1 = req1_valid && (!req0_valid || !m_last);
    e_rdy0 = !reset && free && want0;
    e_rdy1 = !reset && free && want1;
    n_full = m_full; n_y = m_y; n_id = m_id; n_last = m_last; n_c0 = m_c0; n_c1 = m_c1;
    if (reset) begin
      n_full = 0; n_y = 0; n_id = 0; n_last = 1; n_c0 = 0; n_c1 = 0;
    end else if (e_rdy0 || e_rdy1) begin
      n_full = 1; n_id = e_rdy1; n_last = e_rdy1;
      n_y = e_rdy1 ? ref_shift(req1_a, int'(req1_shamt), req1_op)
                   : ref_shift(req0_a, int'(req0_shamt), req0_op);
      if (e_rdy0 && n_c0 < 65535) n_c0++;
      if (e_rdy1 && n_c1 < 65535) n_c1++;
    end else if (rsp_ready) begin
      n_full = 0;
    end
  endtask

  // Inputs are driven just after posedge; settle evaluates the model at negedge.
  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    m_full = n_full; m_y = n_y; m_id = n_id; m_last = n_last; m_c0 = n_c0; m_c1 = n_c1;
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req1_valid = 0; req0_a = 0; req1_a = 0;
    req0_shamt = 0; req1_shamt = 0; req0_op = 0; req1_op = 0; rsp_ready = 1;
  endtask

  task automatic do_reset();
    reset = 1;
    settle(); advance();
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    req0_valid = 1; req1_valid = 1;
    reset = 1;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL reset_ready got %b%b want 00", req0_ready, req1_ready);
      end
      advance();
    end
    reset = 0;
    req0_valid = 0; req1_valid = 0;
    settle();
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_y !== 32'h0 || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL reset_state got v=%b y=%h id=%b want 0/0/0", rsp_valid, rsp_y, rsp_id);
    end
    advance();
  endtask

  task automatic test_basic();
    idle_inputs();
    req0_valid = 1; req0_a = 32'h2D; req0_shamt = 1; req0_op = 2'b00;
    settle();
    n_checks++;
    if (req0_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready0 got %b want 1", req0_ready); end
    advance();
    req0_valid = 0;
    settle();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_y !== 32'h5A || rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL basic_rsp got v=%b y=%h id=%b want 1/5a/0", rsp_valid, rsp_y, rsp_id);
    end
    advance();
  endtask

  task automatic test_back_to_back();
    logic        exp_id;
    logic [31:0] exp_y;
    do_reset();
    idle_inputs();
    req0_valid = 1; req0_a = 32'h1;        req0_shamt = 4; req0_op = 2'b00;
    req1_valid = 1; req1_a = 32'h80000000; req1_shamt = 4; req1_op = 2'b10;
    for (int i = 0; i < 5; i++) begin
      settle();
      n_checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        n_fail++; $display("FAIL b2b_grant[%0d] got %b%b want alternate from req0", i, req0_ready, req1_ready);
      end
      if (i > 0) begin
        exp_id = (i % 2 == 0);
        exp_y  = exp_id ? 32'hF8000000 : 32'h10;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_y !== exp_y) begin
          n_fail++; $display("FAIL b2b_rsp[%0d] got v=%b id=%b y=%h want 1/%b/%h", i, rsp_valid, rsp_id, rsp_y, exp_id, exp_y);
        end
      end
      advance();
    end
  endtask

  task automatic test_stall();
    do_reset();
    idle_inputs();
    req0_valid = 1; req0_a = 32'h0000F00F; req0_shamt = 8; req0_op = 2'b01;
    req1_valid = 1; req1_a = 32'h12345678; req1_shamt = 0; req1_op = 2'b11;
    settle(); advance();
    rsp_ready = 0;
    req0_a = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_y !== 32'h000000F0 || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall[%0d] got v=%b y=%h id=%b rdy=%b%b want 1/000000f0/0/00",
                           i, rsp_valid, rsp_y, rsp_id, req0_ready, req1_ready);
      end
      advance();
    end
    rsp_ready = 1;
    settle();
    n_checks++;
    if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_release got rdy=%b%b want 01", req0_ready, req1_ready);
    end
    advance();
    idle_inputs();
    settle();
    n_checks++;
    if (rsp_y !== 32'h12345678 || rsp_id !== 1'b1) begin
      n_fail++; $display("FAIL stall_next got y=%h id=%b want 12345678/1", rsp_y, rsp_id);
    end
    advance();
  endtask

  task automatic test_edges();
    logic [31:0] va [5];
    logic [4:0]  vs [5];
    logic [1:0]  vo [5];
    logic [31:0] vy [5];
    va = '{32'h2D, 32'h2D, 32'h2D, 32'hFFFFFFFF, 32'hA5A5A5A5};
    vs = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd13};
    vo = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b11};
    vy = '{32'h2D, 32'h2D, 32'h2D, 32'h1, 32'hA5A5A5A5};
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      req1_valid = 1; req1_a = va[i]; req1_shamt = vs[i]; req1_op = vo[i];
      settle(); advance();
      req1_valid = 0;
      settle();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_y !== vy[i] || rsp_id !== 1'b1) begin
        n_fail++; $display("FAIL edge[%0d] got v=%b y=%h id=%b want 1/%h/1", i, rsp_valid, rsp_y, rsp_id, vy[i]);
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    rsp_ready = 0;
    req1_valid = 1; req1_a = 32'h7; req1_op = 2'b11;
    settle(); advance();
    req1_valid = 0;
    do_reset();
    settle();
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", rsp_valid); end
    advance();
    rsp_ready = 1;
    req0_valid = 1; req1_valid = 1;
    settle();
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++; $display("FAIL midreset_prio got rdy=%b%b want 10", req0_ready, req1_ready);
    end
    advance();
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      reset      = ($urandom_range(0, 59) == 0);
      req0_valid = $urandom_range(0, 2) != 0;
      req1_valid = $urandom_range(0, 2) != 0;
      req0_a = $urandom; req1_a = $urandom;
      req0_shamt = 5'($urandom); req1_shamt = 5'($urandom);
      req0_op = 2'($urandom); req1_op = 2'($urandom);
      rsp_ready = $urandom_range(0, 3) != 0;
      settle();
      n_checks++;
      if (req0_ready !== e_rdy0 || req1_ready !== e_rdy1 || rsp_valid !== m_full ||
          (m_full && (rsp_y !== m_y || rsp_id !== m_id))) begin
        n_fail++; $display("FAIL random[%0d] got rdy=%b%b v=%b y=%h id=%b want rdy=%b%b v=%b y=%h id=%b",
                           i, req0_ready, req1_ready, rsp_valid, rsp_y, rsp_id,
                           e_rdy0, e_rdy1, m_full, m_y, m_id);
      end
      advance();
    end
    reset = 0;
    idle_inputs();
`ifdef SHIFT_STATS_EN
    settle();
    n_checks++;
    if (int'(grant_cnt0) != m_c0 || int'(grant_cnt1) != m_c1) begin
      n_fail++; $display("FAIL stats got %0d/%0d want %0d/%0d", grant_cnt0, grant_cnt1, m_c0, m_c1);
    end
    advance();
`endif
  endtask

  task automatic test_stats();
`ifdef SHIFT_STATS_EN
    do_reset();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      req0_valid = (i < 5); req1_valid = (i >= 5);
      settle(); advance();
    end
    idle_inputs();
    settle();
    n_checks++;
    if (grant_cnt0 !== 16'd5 || grant_cnt1 !== 16'd3) begin
      n_fail++; $display("FAIL stats_5_3 got %0d/%0d want 5/3", grant_cnt0, grant_cnt1);
    end
    advance();
`endif
  endtask

  initial begin
    m_full = 0; m_y = 0; m_id = 0; m_last = 1; m_c0 = 0; m_c1 = 0;
    reset = 1;
    idle_inputs();
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_edges();
    test_reset_mid();
    test_stats();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
